// File: rtl/double_eq_arbiter.sv
// Round-robin front end that shares one fixed-latency double_eq comparator among NUM_REQ requesters.
// Results are tagged with the owner's index and returned in grant order through a small response FIFO.
module double_eq_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int CMP_LATENCY = 1,
   parameter int RSP_DEPTH   = 4,
   localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [64*NUM_REQ-1:0] req_a,
   input  logic [64*NUM_REQ-1:0] req_b,
   output logic [63:0]           cmp_a,
   output logic [63:0]           cmp_b,
   input  logic                  cmp_z,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic                  rsp_z,
   output logic                  busy
);

   localparam int PTR_W = $clog2(RSP_DEPTH);
   localparam int CNT_W = $clog2(RSP_DEPTH + CMP_LATENCY + 1) + 1;

   logic [ID_W-1:0]        rr_ptr_reg;
   logic [NUM_REQ-1:0]     grant;
   logic [ID_W-1:0]        grant_id;
   logic                   grant_any;
   logic                   issue_ok;
   int                     cand;

   logic [CMP_LATENCY-1:0] pipe_valid_reg;
   logic [ID_W-1:0]        pipe_id_reg [CMP_LATENCY];
   logic [CNT_W-1:0]       inflight;

   logic [ID_W:0]          mem [RSP_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_reg;
   logic [PTR_W-1:0]       rd_ptr_reg;
   logic [PTR_W:0]         count_reg;
   logic [ID_W:0]          head;
   logic                   push;
   logic                   pop;

   always_comb begin
      inflight = '0;
      for (int j = 0; j < CMP_LATENCY; j++) begin
         inflight = inflight + CNT_W'(pipe_valid_reg[j]);
      end
   end

   // Every issued compare owns a FIFO slot until popped, so the FIFO can never overflow.
   assign issue_ok = (inflight + CNT_W'(count_reg)) < CNT_W'(RSP_DEPTH);

   always_comb begin
      grant     = '0;
      grant_id  = '0;
      grant_any = 1'b0;
      cand      = 0;
      if (issue_ok) begin
         for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(rr_ptr_reg) + i) % NUM_REQ;
            for (int j = 0; j < NUM_REQ; j++) begin
               if (j == cand && !grant_any && req_valid[j]) begin
                  grant_any = 1'b1;
                  grant[j]  = 1'b1;
                  grant_id  = ID_W'(j);
               end
            end
         end
      end
   end

   assign req_ready = grant;

   always_comb begin
      cmp_a = '0;
      cmp_b = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (grant[j]) begin
            cmp_a = req_a[64*j +: 64];
            cmp_b = req_b[64*j +: 64];
         end
      end
   end

   assign push = pipe_valid_reg[CMP_LATENCY-1];
   assign pop  = rsp_valid && rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg     <= ID_W'(NUM_REQ - 1);
         pipe_valid_reg <= '0;
         for (int i = 0; i < CMP_LATENCY; i++) begin
            pipe_id_reg[i] <= '0;
         end
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
      end else begin
         if (grant_any) begin
            rr_ptr_reg <= grant_id;
         end
         pipe_valid_reg[0] <= grant_any;
         pipe_id_reg[0]    <= grant_id;
         for (int i = 1; i < CMP_LATENCY; i++) begin
            pipe_valid_reg[i] <= pipe_valid_reg[i-1];
            pipe_id_reg[i]    <= pipe_id_reg[i-1];
         end
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage carries no reset; stale entries are masked by the count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {pipe_id_reg[CMP_LATENCY-1], cmp_z};
      end
   end

   assign head      = mem[rd_ptr_reg];
   assign rsp_valid = (count_reg != '0);
   assign rsp_id    = rsp_valid ? head[ID_W:1] : '0;
   assign rsp_z     = rsp_valid & head[0];
   assign busy      = (inflight != '0) || (count_reg != '0);

endmodule

// File: tb/tb_double_eq_arbiter.sv
// Bench for double_eq_arbiter: IEEE equality comparator model on the cmp port, an independent
// round-robin/credit model feeding a scoreboard, a vector table and hand-written corner sequences.
module tb_double_eq_arbiter;
   localparam int NUM_REQ     = 4;
   localparam int CMP_LATENCY = 1;
   localparam int RSP_DEPTH   = 4;
   localparam int ID_W        = 2;

   logic                  clk;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [64*NUM_REQ-1:0] req_a;
   logic [64*NUM_REQ-1:0] req_b;
   logic [63:0]           cmp_a;
   logic [63:0]           cmp_b;
   logic                  cmp_z;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic                  rsp_z;
   logic                  busy;

   double_eq_arbiter #(
      .NUM_REQ(NUM_REQ), .CMP_LATENCY(CMP_LATENCY), .RSP_DEPTH(RSP_DEPTH)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_z(cmp_z),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_z(rsp_z), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic ieee_eq(input logic [63:0] a, input logic [63:0] b);
      if ((&a[62:52]) && (|a[51:0])) return 1'b0;
      if ((&b[62:52]) && (|b[51:0])) return 1'b0;
      if (a[62:0] == 63'd0 && b[62:0] == 63'd0) return 1'b1;
      return a == b;
   endfunction

   // Fixed-latency comparator model driving cmp_z.
   logic z_pipe [CMP_LATENCY];
   always @(posedge clk) begin
      z_pipe[0] <= ieee_eq(cmp_a, cmp_b);
      for (int i = 1; i < CMP_LATENCY; i++) z_pipe[i] <= z_pipe[i-1];
   end
   assign cmp_z = z_pipe[CMP_LATENCY-1];

   typedef struct { int id; logic z; } sb_t;
   typedef struct { int id; logic [63:0] a; logic [63:0] b; logic exp_z; } vec_t;

   sb_t  sb_q[$];
   sb_t  sb_e;
   vec_t vecs[6];

   int checks = 0;
   int errors = 0;
   int ptr_m = NUM_REQ - 1;
   int out_m = 0;
   int grants_seen = 0;
   int pops_seen = 0;
   int mon_gid;
   int mon_idx;
   logic [NUM_REQ-1:0] mon_rdy;
   int lat, cnt, g0, p0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: round-robin + credit, sampled mid-cycle; every response is checked on pop.
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_req_ready", 64'(req_ready), 64'd0);
         chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("rst_rsp_id", 64'(rsp_id), 64'd0);
         chk("rst_rsp_z", 64'(rsp_z), 64'd0);
         chk("rst_busy", 64'(busy), 64'd0);
         chk("rst_cmp_a", cmp_a, 64'd0);
         sb_q.delete();
         ptr_m = NUM_REQ - 1;
         out_m = 0;
      end else begin
         mon_rdy = '0;
         mon_gid = -1;
         if (out_m < RSP_DEPTH) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
               mon_idx = (ptr_m + i) % NUM_REQ;
               if (mon_gid < 0 && req_valid[mon_idx]) begin
                  mon_gid = mon_idx;
                  mon_rdy[mon_idx] = 1'b1;
               end
            end
         end
         chk("req_ready", 64'(req_ready), 64'(mon_rdy));
         chk("busy", 64'(busy), 64'(out_m != 0));
         if (mon_gid >= 0) begin
            chk("cmp_a", cmp_a, req_a[64*mon_gid +: 64]);
            chk("cmp_b", cmp_b, req_b[64*mon_gid +: 64]);
            sb_q.push_back('{id: mon_gid, z: ieee_eq(req_a[64*mon_gid +: 64], req_b[64*mon_gid +: 64])});
            ptr_m = mon_gid;
            out_m++;
            grants_seen++;
         end else begin
            chk("cmp_a_idle", cmp_a, 64'd0);
         end
         if (rsp_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_spurious: got rsp_valid=1 id=%0d expected no response", rsp_id);
            end else if (rsp_ready) begin
               sb_e = sb_q.pop_front();
               chk("sb_rsp_id", 64'(rsp_id), 64'(sb_e.id));
               chk("sb_rsp_z", 64'(rsp_z), 64'(sb_e.z));
               out_m--;
               pops_seen++;
            end
         end
      end
   end

   task automatic drain();
      int n;
      n = 0;
      while ((busy || rsp_valid) && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("drain_done", 64'(n < 60), 64'd1);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      req_valid = '0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      req_valid = '0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b1;
      vecs[0] = '{0, 64'h3FF0000000000000, 64'h3FF0000000000000, 1'b1};
      vecs[1] = '{1, 64'h3FF0000000000000, 64'h4000000000000000, 1'b0};
      vecs[2] = '{2, 64'h0000000000000000, 64'h8000000000000000, 1'b1};
      vecs[3] = '{3, 64'h7FF8000000000000, 64'h7FF8000000000000, 1'b0};
      vecs[4] = '{1, 64'h7FF0000000000000, 64'h7FF0000000000000, 1'b1};
      vecs[5] = '{0, 64'h0000000000000001, 64'h0000000000000002, 1'b0};
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Single requests from the table: grant, latency, tag, result, idle afterwards.
      for (int t = 0; t < 6; t++) begin
         @(posedge clk);
         #1;
         req_a[64*vecs[t].id +: 64] = vecs[t].a;
         req_b[64*vecs[t].id +: 64] = vecs[t].b;
         req_valid = NUM_REQ'(1) << vecs[t].id;
         @(negedge clk);
         chk("tbl_grant", 64'(req_ready), 64'(NUM_REQ'(1) << vecs[t].id));
         @(posedge clk);
         #1 req_valid = '0;
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
         end while (!rsp_valid && lat < 20);
         chk("tbl_latency", 64'(lat), 64'(CMP_LATENCY + 1));
         chk("tbl_rsp_id", 64'(rsp_id), 64'(vecs[t].id));
         chk("tbl_rsp_z", 64'(rsp_z), 64'(vecs[t].exp_z));
         @(negedge clk);
         chk("tbl_busy_after_pop", 64'(busy), 64'd0);
      end

      // All four requesting continuously: strict 0,1,2,3 rotation at full rate.
      pulse_reset();
      req_a = {64'h7FF8000000000000, 64'h0000000000000000, 64'h3FF0000000000000, 64'h3FF0000000000000};
      req_b = {64'h7FF8000000000000, 64'h8000000000000000, 64'h4000000000000000, 64'h3FF0000000000000};
      @(posedge clk);
      #1 req_valid = '1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("rr_grant", 64'(req_ready), 64'(NUM_REQ'(1) << (c % NUM_REQ)));
      end
      @(posedge clk);
      #1 req_valid = '0;
      drain();

      // Backpressure: exactly RSP_DEPTH grants, then stall until a response drains.
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      g0 = grants_seen;
      req_valid = '1;
      repeat (10) @(negedge clk);
      chk("bp_grant_count", 64'(grants_seen - g0), 64'(RSP_DEPTH));
      chk("bp_ready_low", 64'(req_ready), 64'd0);
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      g0 = grants_seen;
      p0 = pops_seen;
      cnt = 0;
      while (grants_seen == g0 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("bp_resume", 64'(cnt < 20), 64'd1);
      chk("bp_pop_before_resume", 64'(pops_seen - p0 >= 1), 64'd1);
      @(posedge clk);
      #1 req_valid = '0;
      drain();

      // Fairness between requesters 1 and 3 starting from pointer 3.
      pulse_reset();
      @(posedge clk);
      #1 req_valid = 4'b1010;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("fair_grant", 64'(req_ready), (c % 2 == 0) ? 64'h2 : 64'h8);
      end
      @(posedge clk);
      #1 req_valid = '0;
      drain();

      // Reset with results in flight and buffered: nothing stale may appear afterwards.
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      req_valid = '1;
      repeat (4) @(negedge clk);
      chk("mid_busy_before_rst", 64'(busy), 64'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      req_valid = '0;
      #1;
      chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_idle", 64'(rsp_valid), 64'd0);
      @(posedge clk);
      #1 req_valid = 4'b0101;
      @(negedge clk);
      chk("post_rst_grant", 64'(req_ready), 64'h1);
      @(posedge clk);
      #1 req_valid = '0;
      drain();

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
